// File: rtl/vram_pkg.sv
// vram_pkg: shared definitions for the video RAM arbiter.
//   src_e            read-return source tag carried alongside each RAM read
//   DEF_ADDR_W       default RAM address width
//   DEF_DATA_W       default RAM data width
//   DEF_STARVE_LIMIT default wait cycles before CPU/keyboard pre-empts VGA
package vram_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_VGA  = 2'd1,
        SRC_CPU  = 2'd2,
        SRC_KBD  = 2'd3
    } src_e;

    localparam int unsigned DEF_ADDR_W       = 12;
    localparam int unsigned DEF_DATA_W       = 8;
    localparam int unsigned DEF_STARVE_LIMIT = 15;

endpackage

// File: rtl/vram_rd_pipe.sv
// vram_rd_pipe: tracks the source of each RAM read through the two cycles of RAM latency
// and steers the returned word to the VGA or CPU read port.
//   clk, rst_n           clock, asynchronous active-low reset
//   issue_tag            source of the read issued at this edge (SRC_NONE for none/write)
//   ram_rdata            RAM read data
//   vga_data, vga_valid  VGA read return (valid is a 1-cycle pulse)
//   cpu_rdata, cpu_rvalid CPU read return (valid is a 1-cycle pulse)
module vram_rd_pipe
    import vram_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  src_e              issue_tag,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid
);

    // tag_s1: command is on the RAM port; tag_s2: RAM data arrives this cycle.
    src_e              tag_s1_q, tag_s2_q;
    logic [DATA_W-1:0] vga_data_q, cpu_rdata_q;
    logic              vga_valid_q, cpu_rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_s1_q     <= SRC_NONE;
            tag_s2_q     <= SRC_NONE;
            vga_data_q   <= '0;
            vga_valid_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            tag_s1_q     <= issue_tag;
            tag_s2_q     <= tag_s1_q;
            vga_valid_q  <= (tag_s2_q == SRC_VGA);
            cpu_rvalid_q <= (tag_s2_q == SRC_CPU);
            if (tag_s2_q == SRC_VGA) begin
                vga_data_q <= ram_rdata;
            end
            if (tag_s2_q == SRC_CPU) begin
                cpu_rdata_q <= ram_rdata;
            end
        end
    end

    assign vga_data   = vga_data_q;
    assign vga_valid  = vga_valid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port video RAM arbiter. VGA scan-out has priority; CPU and keyboard
// share round-robin fairness, and a starvation counter lets them pre-empt VGA after
// STARVE_LIMIT waiting cycles. Issues a registered RAM command and routes read data back.
//   Clock, Reset                       clock, asynchronous active-low reset
//   iVgaReq/iVgaAddr/oVgaGnt           VGA read request port
//   oVgaData/oVgaValid                 VGA read return
//   oVgaMiss                           pulse: VGA pre-empted by a starvation grant
//   iCpuReq/iCpuWe/iCpuAddr/iCpuWData  CPU read/write request port, oCpuGnt grant
//   oCpuRData/oCpuRValid               CPU read return
//   iKbdReq/iKbdAddr/iKbdWData         keyboard write request port, oKbdGnt grant
//   oRamEn/oRamWe/oRamAddr/oRamWData   registered RAM command
//   iRamRData                          RAM read data (one cycle after the command)
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iVgaReq,
    input  logic [ADDR_W-1:0] iVgaAddr,
    output logic              oVgaGnt,
    output logic [DATA_W-1:0] oVgaData,
    output logic              oVgaValid,
    output logic              oVgaMiss,
    input  logic              iCpuReq,
    input  logic              iCpuWe,
    input  logic [ADDR_W-1:0] iCpuAddr,
    input  logic [DATA_W-1:0] iCpuWData,
    output logic              oCpuGnt,
    output logic [DATA_W-1:0] oCpuRData,
    output logic              oCpuRValid,
    input  logic              iKbdReq,
    input  logic [ADDR_W-1:0] iKbdAddr,
    input  logic [DATA_W-1:0] iKbdWData,
    output logic              oKbdGnt,
    output logic              oRamEn,
    output logic              oRamWe,
    output logic [ADDR_W-1:0] oRamAddr,
    output logic [DATA_W-1:0] oRamWData,
    input  logic [DATA_W-1:0] iRamRData
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              rr_pref_cpu_q, rr_pref_cpu_d;
    logic              vga_miss_q, vga_miss_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic starve, rr_any, rr_cpu, rr_kbd, rr_sel;
    logic vga_gnt, cpu_gnt, kbd_gnt;
    src_e issue_tag;

    // Grant decision
    assign starve  = (wait_cnt_q == CNT_W'(STARVE_LIMIT));
    assign rr_any  = iCpuReq | iKbdReq;
    assign rr_cpu  = iCpuReq & (~iKbdReq | rr_pref_cpu_q);
    assign rr_kbd  = iKbdReq & ~rr_cpu;
    // The CPU/keyboard pair owns the slot when VGA is idle or the pair has starved.
    assign rr_sel  = ~iVgaReq | (starve & rr_any);

    assign vga_gnt = Reset & iVgaReq & ~rr_sel;
    assign cpu_gnt = Reset & rr_sel & rr_cpu;
    assign kbd_gnt = Reset & rr_sel & rr_kbd;

    assign oVgaGnt = vga_gnt;
    assign oCpuGnt = cpu_gnt;
    assign oKbdGnt = kbd_gnt;

    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        rr_pref_cpu_d = rr_pref_cpu_q;
        ram_en_d      = vga_gnt | cpu_gnt | kbd_gnt;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        issue_tag     = SRC_NONE;
        vga_miss_d    = starve & rr_any & iVgaReq & Reset;

        if (vga_gnt) begin
            ram_addr_d = iVgaAddr;
            issue_tag  = SRC_VGA;
        end else if (cpu_gnt) begin
            ram_we_d    = iCpuWe;
            ram_addr_d  = iCpuAddr;
            ram_wdata_d = iCpuWData;
            issue_tag   = iCpuWe ? SRC_NONE : SRC_CPU;
        end else if (kbd_gnt) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = iKbdAddr;
            ram_wdata_d = iKbdWData;
        end

        if (cpu_gnt || kbd_gnt) begin
            wait_cnt_d    = '0;
            rr_pref_cpu_d = kbd_gnt;
        end else if (rr_any && !starve) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wait_cnt_q    <= '0;
            rr_pref_cpu_q <= 1'b1;
            vga_miss_q    <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            rr_pref_cpu_q <= rr_pref_cpu_d;
            vga_miss_q    <= vga_miss_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
        end
    end

    assign oVgaMiss  = vga_miss_q;
    assign oRamEn    = ram_en_q;
    assign oRamWe    = ram_we_q;
    assign oRamAddr  = ram_addr_q;
    assign oRamWData = ram_wdata_q;

    vram_rd_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk        (Clock),
        .rst_n      (Reset),
        .issue_tag  (issue_tag),
        .ram_rdata  (iRamRData),
        .vga_data   (oVgaData),
        .vga_valid  (oVgaValid),
        .cpu_rdata  (oCpuRData),
        .cpu_rvalid (oCpuRValid)
    );

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed bench for vram_arbiter with a behavioural reference model
// and a 1-cycle synchronous RAM preloaded with mem[a] = a[7:0].
module tb_vram_arbiter;

    localparam int LIM = 15;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        iVgaReq = 1'b0;
    logic [11:0] iVgaAddr = '0;
    logic        iCpuReq = 1'b0;
    logic        iCpuWe = 1'b0;
    logic [11:0] iCpuAddr = '0;
    logic [7:0]  iCpuWData = '0;
    logic        iKbdReq = 1'b0;
    logic [11:0] iKbdAddr = '0;
    logic [7:0]  iKbdWData = '0;
    logic        oVgaGnt, oVgaValid, oVgaMiss, oCpuGnt, oCpuRValid, oKbdGnt, oRamEn, oRamWe;
    logic [7:0]  oVgaData, oCpuRData, oRamWData;
    logic [11:0] oRamAddr;
    logic [7:0]  ram_rdata = '0;

    vram_arbiter dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iVgaReq    (iVgaReq),
        .iVgaAddr   (iVgaAddr),
        .oVgaGnt    (oVgaGnt),
        .oVgaData   (oVgaData),
        .oVgaValid  (oVgaValid),
        .oVgaMiss   (oVgaMiss),
        .iCpuReq    (iCpuReq),
        .iCpuWe     (iCpuWe),
        .iCpuAddr   (iCpuAddr),
        .iCpuWData  (iCpuWData),
        .oCpuGnt    (oCpuGnt),
        .oCpuRData  (oCpuRData),
        .oCpuRValid (oCpuRValid),
        .iKbdReq    (iKbdReq),
        .iKbdAddr   (iKbdAddr),
        .iKbdWData  (iKbdWData),
        .oKbdGnt    (oKbdGnt),
        .oRamEn     (oRamEn),
        .oRamWe     (oRamWe),
        .oRamAddr   (oRamAddr),
        .oRamWData  (oRamWData),
        .iRamRData  (ram_rdata)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bench RAM: 1-cycle synchronous read
    logic [7:0] ram [0:4095];
    initial for (int a = 0; a < 4096; a++) ram[a] = 8'(a);
    always @(posedge Clock) begin
        if (oRamEn === 1'b1) begin
            if (oRamWe) ram[oRamAddr] <= oRamWData;
            else        ram_rdata     <= ram[oRamAddr];
        end
    end

    // Reference model: who should be granted, what the RAM port should show,
    // and a queue of reads due back at a given edge number.
    typedef struct {
        int         due;
        bit         vga;
        logic [7:0] data;
    } rd_t;

    rd_t        rq[$];
    rd_t        r_tmp;
    logic [7:0] mem_m [0:4095];
    int         wait_m, edge_n, g_m, rr_m;
    bit         pref_m, starve_take_m;
    logic       en_m, we_m, vv_m, cv_m, miss_m;
    logic [11:0] addr_m;
    logic [7:0] wdata_m, vd_m, cd_m;

    // Observations for the hand-computed checks
    logic [7:0] vga_seen[$];
    logic [7:0] cpu_seen[$];
    int         cpu_seen_edge[$];
    int         miss_cnt;

    initial for (int a = 0; a < 4096; a++) mem_m[a] = 8'(a);

    task automatic model_reset();
        wait_m = 0; pref_m = 1'b1; en_m = 1'b0; we_m = 1'b0; addr_m = '0; wdata_m = '0;
        vv_m = 1'b0; cv_m = 1'b0; miss_m = 1'b0; vd_m = '0; cd_m = '0;
        rq.delete();
    endtask

    initial begin
        edge_n   = 0;
        miss_cnt = 0;
        model_reset();
        forever begin
            @(negedge Clock);
            if (!Reset) model_reset();
            g_m = 0;
            starve_take_m = 1'b0;
            if (Reset) begin
                if (iCpuReq && iKbdReq) rr_m = pref_m ? 2 : 3;
                else if (iCpuReq)       rr_m = 2;
                else if (iKbdReq)       rr_m = 3;
                else                    rr_m = 0;
                if (wait_m >= LIM && rr_m != 0) begin
                    g_m = rr_m;
                    starve_take_m = 1'b1;
                end else if (iVgaReq) begin
                    g_m = 1;
                end else begin
                    g_m = rr_m;
                end
            end
            check("vga_gnt", 32'(oVgaGnt), 32'(g_m == 1));
            check("cpu_gnt", 32'(oCpuGnt), 32'(g_m == 2));
            check("kbd_gnt", 32'(oKbdGnt), 32'(g_m == 3));
            check("ram_en", 32'(oRamEn), 32'(en_m));
            check("ram_we", 32'(oRamWe), 32'(we_m));
            if (en_m) check("ram_addr", 32'(oRamAddr), 32'(addr_m));
            if (en_m && we_m) check("ram_wdata", 32'(oRamWData), 32'(wdata_m));
            check("vga_valid", 32'(oVgaValid), 32'(vv_m));
            check("vga_data", 32'(oVgaData), 32'(vd_m));
            check("cpu_rvalid", 32'(oCpuRValid), 32'(cv_m));
            check("cpu_rdata", 32'(oCpuRData), 32'(cd_m));
            check("vga_miss", 32'(oVgaMiss), 32'(miss_m));
            if (oVgaValid === 1'b1) vga_seen.push_back(oVgaData);
            if (oCpuRValid === 1'b1) begin
                cpu_seen.push_back(oCpuRData);
                cpu_seen_edge.push_back(edge_n);
            end
            if (oVgaMiss === 1'b1) miss_cnt++;

            @(posedge Clock);
            edge_n++;
            if (Reset) begin
                vv_m = 1'b0;
                cv_m = 1'b0;
                while (rq.size() > 0 && rq[0].due == edge_n) begin
                    r_tmp = rq.pop_front();
                    if (r_tmp.vga) begin vv_m = 1'b1; vd_m = r_tmp.data; end
                    else           begin cv_m = 1'b1; cd_m = r_tmp.data; end
                end
                miss_m = starve_take_m && iVgaReq;
                en_m   = (g_m != 0);
                we_m   = 1'b0;
                if (g_m == 1) begin
                    addr_m = iVgaAddr;
                    r_tmp.due = edge_n + 2; r_tmp.vga = 1'b1; r_tmp.data = mem_m[iVgaAddr];
                    rq.push_back(r_tmp);
                end else if (g_m == 2) begin
                    addr_m = iCpuAddr; wdata_m = iCpuWData; we_m = iCpuWe;
                    if (iCpuWe) begin
                        mem_m[iCpuAddr] = iCpuWData;
                    end else begin
                        r_tmp.due = edge_n + 2; r_tmp.vga = 1'b0; r_tmp.data = mem_m[iCpuAddr];
                        rq.push_back(r_tmp);
                    end
                end else if (g_m == 3) begin
                    addr_m = iKbdAddr; wdata_m = iKbdWData; we_m = 1'b1;
                    mem_m[iKbdAddr] = iKbdWData;
                end
                if (g_m == 2 || g_m == 3) begin
                    wait_m = 0;
                    pref_m = (g_m == 3);
                end else if ((iCpuReq || iKbdReq) && wait_m < LIM) begin
                    wait_m++;
                end
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_reqs();
        iVgaReq = 1'b0; iCpuReq = 1'b0; iKbdReq = 1'b0; iCpuWe = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        clear_reqs();
        @(negedge Clock);
        check("rst_ram_en", 32'(oRamEn), 0);
        check("rst_cpu_rvalid", 32'(oCpuRValid), 0);
        step();
        Reset = 1'b1;
    endtask

    int k, gnt_cyc;

    initial begin
        #1 Reset = 1'b0;

        // 1: VGA streaming 0x010..0x01F
        do_reset();
        vga_seen.delete();
        miss_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            iVgaReq  = 1'b1;
            iVgaAddr = 12'(16 + i);
            @(negedge Clock);
            check("t1_vga_gnt", 32'(oVgaGnt), 1);
            step();
        end
        iVgaReq = 1'b0;
        repeat (4) step();
        check("t1_count", 32'(vga_seen.size()), 16);
        for (int i = 0; i < vga_seen.size() && i < 16; i++)
            check("t1_data", 32'(vga_seen[i]), 32'(16 + i));
        check("t1_miss", 32'(miss_cnt), 0);

        // 2: CPU write then read-back of 0x0A5
        do_reset();
        cpu_seen.delete();
        cpu_seen_edge.delete();
        iCpuReq = 1'b1; iCpuWe = 1'b1; iCpuAddr = 12'h0A5; iCpuWData = 8'h3C;
        @(negedge Clock);
        check("t2_wr_gnt", 32'(oCpuGnt), 1);
        step();
        iCpuWe = 1'b0;
        @(negedge Clock);
        check("t2_rd_gnt", 32'(oCpuGnt), 1);
        step();
        k = edge_n;
        iCpuReq = 1'b0;
        repeat (4) step();
        check("t2_count", 32'(cpu_seen.size()), 1);
        if (cpu_seen.size() > 0) begin
            check("t2_rdata", 32'(cpu_seen[0]), 32'h3C);
            check("t2_latency", 32'(cpu_seen_edge[0]), 32'(k + 2));
        end

        // 3: CPU and keyboard contending alternate, CPU first
        do_reset();
        iCpuReq = 1'b1; iCpuWe = 1'b0; iCpuAddr = 12'h001;
        iKbdReq = 1'b1; iKbdAddr = 12'h400; iKbdWData = 8'h5A;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            check("t3_cpu_gnt", 32'(oCpuGnt), 32'(i % 2 == 0));
            check("t3_kbd_gnt", 32'(oKbdGnt), 32'(i % 2 == 1));
            step();
        end
        clear_reqs();
        repeat (3) step();

        // 4: VGA continuous with a pending CPU read -> starvation grant in cycle 15
        do_reset();
        miss_cnt = 0;
        gnt_cyc  = -1;
        iVgaReq = 1'b1;
        iCpuReq = 1'b1; iCpuWe = 1'b0; iCpuAddr = 12'h055;
        for (int i = 0; i < 20; i++) begin
            iVgaAddr = 12'(256 + i);
            @(negedge Clock);
            if (iCpuReq && oCpuGnt === 1'b1) begin
                gnt_cyc = i;
                check("t4_vga_gnt_off", 32'(oVgaGnt), 0);
            end
            if (i == 16) begin
                check("t4_miss_c16", 32'(oVgaMiss), 1);
                check("t4_wait_cnt", 32'(dut.wait_cnt_q), 0);
            end
            step();
            if (gnt_cyc == i) iCpuReq = 1'b0;
        end
        check("t4_gnt_cycle", 32'(gnt_cyc), 15);
        iVgaReq = 1'b0;
        repeat (4) step();
        check("t4_miss_cnt", 32'(miss_cnt), 1);

        // 5: reset with a CPU read in flight
        do_reset();
        cpu_seen.delete();
        iCpuReq = 1'b1; iCpuWe = 1'b0; iCpuAddr = 12'h033;
        @(negedge Clock);
        check("t5_gnt", 32'(oCpuGnt), 1);
        step();
        iCpuReq = 1'b0;
        step();
        Reset = 1'b0;
        @(negedge Clock);
        check("t5_rst_cpu_gnt", 32'(oCpuGnt), 0);
        check("t5_rst_ram_en", 32'(oRamEn), 0);
        check("t5_rst_ram_addr", 32'(oRamAddr), 0);
        check("t5_rst_cpu_rdata", 32'(oCpuRData), 0);
        check("t5_rst_vga_data", 32'(oVgaData), 0);
        check("t5_rst_miss", 32'(oVgaMiss), 0);
        step();
        step();
        Reset = 1'b1;
        repeat (4) step();
        check("t5_no_valid", 32'(cpu_seen.size()), 0);
        iCpuReq = 1'b1; iKbdReq = 1'b1; iKbdAddr = 12'h401; iKbdWData = 8'h01;
        @(negedge Clock);
        check("t5_cpu_first", 32'(oCpuGnt), 1);
        check("t5_kbd_wait", 32'(oKbdGnt), 0);
        step();
        clear_reqs();
        repeat (3) step();

        // 6: keyboard preferred, writes 0x77 to 0x200 ahead of a CPU read of 0x200
        do_reset();
        cpu_seen.delete();
        iCpuReq = 1'b1; iCpuWe = 1'b1; iCpuAddr = 12'h300; iCpuWData = 8'h11;
        @(negedge Clock);
        check("t6_pre_gnt", 32'(oCpuGnt), 1);
        step();
        iCpuWe = 1'b0; iCpuAddr = 12'h200;
        iKbdReq = 1'b1; iKbdAddr = 12'h200; iKbdWData = 8'h77;
        @(negedge Clock);
        check("t6_kbd_gnt", 32'(oKbdGnt), 1);
        check("t6_cpu_wait", 32'(oCpuGnt), 0);
        step();
        iKbdReq = 1'b0;
        @(negedge Clock);
        check("t6_cpu_gnt", 32'(oCpuGnt), 1);
        step();
        iCpuReq = 1'b0;
        repeat (4) step();
        check("t6_count", 32'(cpu_seen.size()), 1);
        if (cpu_seen.size() > 0) check("t6_rdata", 32'(cpu_seen[0]), 32'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
